regfile_dump_unit: RTL and testbench
====================================

Name: regfile_dump_unit

Overview:
- Debug readout engine on the read side of the 32x32 register file.
- On a start request it walks register addresses in order, captures each read value, and streams it out over a valid/ready port with index and last tags.
- Sits between the register file read port (muxed in debug mode) and the debug/trace interface.
- While a dump is in progress it asserts a hold to the core so the captured image is a consistent snapshot.

Parameters:
- NUM_REGS, 32, number of registers walked; last index is NUM_REGS-1.
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, register data width.
- SKIP_X0, 0, if 1 the walk starts at index 1 (x0 is hardwired zero).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle dump request; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until DONE exits.
- done  output  1  one-cycle pulse after the last beat handshakes.
- rf_hold  output  1  equals busy; the core must suppress reg_write while high.
- rf_raddr  output  ADDR_WIDTH  read address to the register file read port.
- rf_rdata  input  DATA_WIDTH  combinational read data for rf_raddr, same cycle.
- out_valid  output  1  stream beat valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_WIDTH  captured register value.
- out_index  output  ADDR_WIDTH  register number of out_data.
- out_last  output  1  high with the beat whose out_index == NUM_REGS-1.

Behaviour:
- Reset (async, any state) forces the following. State goes to IDLE. idx is cleared to 0. busy, done, rf_hold, out_valid and out_last go to 0. out_data and out_index go to 0. rf_raddr goes to 0.
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - rf_raddr = 0.
  - If start: idx <= (SKIP_X0 ? 1 : 0) and go to LOAD.
  - start is ignored in every other state (no queuing).
- LOAD:
  - rf_raddr = idx (combinational).
  - At the clock edge: out_data <= rf_rdata, out_index <= idx, out_last <= (idx == NUM_REGS-1). Then go to SEND.
- SEND:
  - out_valid = 1.
  - out_data, out_index and out_last stay stable while out_valid && !out_ready.
  - When out_ready is high: if out_last, go to DONE; else idx <= idx+1 and go to LOAD.
  - out_valid deasserts in the cycle after the handshake.
- DONE:
  - done = 1 for exactly one cycle, busy = 1.
  - Next state is IDLE; busy drops in that cycle.
- busy = (state != IDLE). rf_hold = busy.
- Throughput: 2 cycles per register with out_ready held high. A full dump with SKIP_X0=0 takes 64 cycles from LOAD entry to the last handshake, plus 1 DONE cycle.
- idx never wraps. The increment only occurs when idx < NUM_REGS-1.
- out_ready high outside SEND has no effect.
- Reset asserted mid-dump aborts with no done pulse. A new start after reset begins a fresh walk.
- Captured value is whatever rf_rdata shows during the LOAD cycle. With rf_hold honoured, this equals the register contents at start acceptance.

Test Plan:
- Reset, preload x1=0x11111111 … x31=0x1F1F1F1F; start, out_ready=1 -> 32 beats with indices 0..31. Beat 0 data=0. Beat 5 data=0x05050505. out_last only on index 31. done pulses one cycle after the index-31 handshake. busy spans 65 cycles.
- SKIP_X0=1, same preload -> 31 beats, first out_index=1 data=0x11111111, last index 31 with out_last=1.
- Backpressure: out_ready low for 5 cycles at index 7 -> out_valid held, out_data=0x07070707 and out_index=7 stable throughout. Index 8 follows 2 cycles after ready rises.
- Start pulsed again at index 10 while busy -> ignored. Exactly one dump of 32 beats, one done pulse.
- Async reset asserted at index 12 in SEND -> out_valid, busy and rf_hold drop immediately, no done. A new start yields index 0 first.
- Write attempt on the core side while rf_hold=1 (x3 <- 0xDEADBEEF) is suppressed by the core -> beat 3 shows 0x03030303.

Source files
------------

// File: rtl/regfile_dump_unit.sv
// rtl/regfile_dump_unit.sv - walks the register file read port and streams each captured value with index/last tags
module regfile_dump_unit #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int SKIP_X0    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rf_hold,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = (SKIP_X0 != 0) ? ADDR_WIDTH'(1) : '0;

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;

  // The read port is only driven during LOAD so it stays parked at x0 otherwise.
  assign rf_raddr = (state == S_LOAD) ? idx : '0;
  assign rf_hold  = busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx   <= FIRST_IDX;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          out_data  <= rf_rdata;
          out_index <= idx;
          out_last  <= (idx == LAST_IDX);
          out_valid <= 1'b1;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              if (idx < LAST_IDX) idx <= idx + 1'b1;
              state <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// tb/tb_regfile_dump_unit.sv - table-driven and randomized bench for regfile_dump_unit
module tb_regfile_dump_unit;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic start_drv, ready_drv, sel;
  logic start0, start1;
  assign start0 = start_drv & ~sel;
  assign start1 = start_drv & sel;

  logic busy0, done0, hold0, valid0, last0;
  logic busy1, done1, hold1, valid1, last1;
  logic [AW-1:0] raddr0, raddr1, index0, index1;
  logic [DW-1:0] rdata0, rdata1, data0, data1;
  logic [DW-1:0] regs [NR];

  always_comb begin
    rdata0 = regs[raddr0];
    rdata1 = regs[raddr1];
  end

  regfile_dump_unit #(.NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SKIP_X0(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0), .rf_hold(hold0),
    .rf_raddr(raddr0), .rf_rdata(rdata0), .out_valid(valid0), .out_ready(ready_drv),
    .out_data(data0), .out_index(index0), .out_last(last0));

  regfile_dump_unit #(.NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SKIP_X0(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1), .rf_hold(hold1),
    .rf_raddr(raddr1), .rf_rdata(rdata1), .out_valid(valid1), .out_ready(ready_drv),
    .out_data(data1), .out_index(index1), .out_last(last1));

  logic          m_busy, m_done, m_hold, m_valid, m_last;
  logic [AW-1:0] m_index;
  logic [DW-1:0] m_data;
  assign m_busy  = sel ? busy1  : busy0;
  assign m_done  = sel ? done1  : done0;
  assign m_hold  = sel ? hold1  : hold0;
  assign m_valid = sel ? valid1 : valid0;
  assign m_last  = sel ? last1  : last0;
  assign m_index = sel ? index1 : index0;
  assign m_data  = sel ? data1  : data0;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  typedef struct {
    bit       skip;
    int       stall_at;
    int       stall_len;
    int       restart_at;
    int       write_idx;
    int       exp_beats;
    int       exp_first;
    int       exp_busy;
    int       probe_idx;
    logic [31:0] probe_data;
  } vec_t;

  logic [AW-1:0] got_idx[$];
  logic [DW-1:0] got_data[$];
  logic          got_last[$];
  int            got_cyc[$];
  logic [AW-1:0] exp_idx[$];
  logic [DW-1:0] exp_data[$];
  int busy_cnt, done_cnt, hold_err, stab_err, timed_out;

  task automatic preload_pattern();
    regs[0] = '0;
    for (int i = 1; i < NR; i++) regs[i] = {4{8'(i)}};
    regs[1] = 32'h1111_1111;
  endtask

  task automatic preload_random();
    regs[0] = '0;
    for (int i = 1; i < NR; i++) regs[i] = $urandom;
  endtask

  // Reference: the dump is the snapshot of the register file at start, indices first..NR-1.
  task automatic run_dump(input bit which, input int stall_at, input int stall_len,
                          input int restart_at, input int write_idx, input bit rnd);
    int cyc, stall_left;
    bit pv, restarted;
    logic [DW-1:0] pd;
    logic [AW-1:0] pi;
    logic pl;
    sel = which;
    got_idx.delete(); got_data.delete(); got_last.delete(); got_cyc.delete();
    exp_idx.delete(); exp_data.delete();
    busy_cnt = 0; done_cnt = 0; hold_err = 0; stab_err = 0; timed_out = 0;
    for (int i = (which ? 1 : 0); i < NR; i++) begin
      exp_idx.push_back(AW'(i));
      exp_data.push_back((i == 0) ? '0 : regs[i]);
    end
    @(negedge clk); start_drv = 1'b1; ready_drv = 1'b1;
    @(negedge clk); start_drv = 1'b0;
    cyc = 0; pv = 0; stall_left = stall_len; restarted = 0;
    pd = '0; pi = '0; pl = 1'b0;
    while (m_busy) begin
      if (cyc >= 1000) begin timed_out = 1; break; end
      busy_cnt++;
      if (m_done) done_cnt++;
      if (m_hold !== m_busy) hold_err++;
      if (write_idx > 0 && cyc == 3 && !m_hold) regs[write_idx] = 32'hDEAD_BEEF;
      start_drv = 1'b0;
      if (restart_at >= 0 && !restarted && m_valid && m_index == restart_at) begin
        start_drv = 1'b1; restarted = 1;
      end
      if (rnd) ready_drv = ($urandom_range(0, 2) != 0);
      else if (m_valid && m_index == stall_at && stall_left > 0) begin
        ready_drv = 1'b0; stall_left--;
      end else ready_drv = 1'b1;
      if (pv && m_valid && (m_data !== pd || m_index !== pi || m_last !== pl)) stab_err++;
      pv = m_valid && !ready_drv; pd = m_data; pi = m_index; pl = m_last;
      if (m_valid && ready_drv) begin
        got_idx.push_back(m_index); got_data.push_back(m_data);
        got_last.push_back(m_last); got_cyc.push_back(cyc);
      end
      @(negedge clk); cyc++;
    end
    start_drv = 1'b0; ready_drv = 1'b0;
  endtask

  function automatic int beat_mismatches();
    int n = 0;
    if (got_idx.size() != exp_idx.size()) return 999;
    for (int i = 0; i < got_idx.size(); i++)
      if (got_idx[i] !== exp_idx[i] || got_data[i] !== exp_data[i] ||
          got_last[i] !== (exp_idx[i] == AW'(NR - 1))) n++;
    return n;
  endfunction

  function automatic logic [DW-1:0] beat_data_of(input int index);
    for (int i = 0; i < got_idx.size(); i++)
      if (got_idx[i] == AW'(index)) return got_data[i];
    return 'x;
  endfunction

  function automatic int gap_after(input int index);
    for (int i = 0; i + 1 < got_idx.size(); i++)
      if (got_idx[i] == AW'(index)) return got_cyc[i+1] - got_cyc[i];
    return -1;
  endfunction

  vec_t vt[6];

  initial begin
    vt[0] = '{0, -1, 0, -1, -1, 32, 0, 65,  5, 32'h0505_0505};
    vt[1] = '{1, -1, 0, -1, -1, 31, 1, 63,  1, 32'h1111_1111};
    vt[2] = '{0,  7, 5, -1, -1, 32, 0, 70,  7, 32'h0707_0707};
    vt[3] = '{0, -1, 0, 10, -1, 32, 0, 65, 10, 32'h0A0A_0A0A};
    vt[4] = '{0, -1, 0, -1,  3, 32, 0, 65,  3, 32'h0303_0303};
    vt[5] = '{1, 20, 3, -1, -1, 31, 1, 66, 31, 32'h1F1F_1F1F};

    reset = 1'b1; start_drv = 1'b0; ready_drv = 1'b0; sel = 1'b0;
    preload_pattern();
    #12;
    check("reset_dut0", {busy0, done0, hold0, valid0, last0, raddr0, index0, data0}, '0);
    check("reset_dut1", {busy1, done1, hold1, valid1, last1, raddr1, index1, data1}, '0);
    @(negedge clk); reset = 1'b0;
    ready_drv = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready_no_effect", {busy0, valid0, done0}, '0);

    for (int r = 0; r < 6; r++) begin
      preload_pattern();
      run_dump(vt[r].skip, vt[r].stall_at, vt[r].stall_len, vt[r].restart_at, vt[r].write_idx, 1'b0);
      check($sformatf("row%0d_timeout", r), timed_out, 0);
      check($sformatf("row%0d_beats", r), got_idx.size(), vt[r].exp_beats);
      check($sformatf("row%0d_first_idx", r), (got_idx.size() > 0) ? got_idx[0] : 'x, vt[r].exp_first);
      check($sformatf("row%0d_busy_cycles", r), busy_cnt, vt[r].exp_busy);
      check($sformatf("row%0d_done_pulses", r), done_cnt, 1);
      check($sformatf("row%0d_hold_eq_busy", r), hold_err, 0);
      check($sformatf("row%0d_stable", r), stab_err, 0);
      check($sformatf("row%0d_model", r), beat_mismatches(), 0);
      check($sformatf("row%0d_probe", r), beat_data_of(vt[r].probe_idx), vt[r].probe_data);
      if (vt[r].stall_len > 0)
        check($sformatf("row%0d_gap_after_stall", r), gap_after(vt[r].stall_at), 2);
      repeat (2) @(negedge clk);
    end

    // Async reset while index 12 is on the stream.
    preload_pattern();
    sel = 1'b0; ready_drv = 1'b1;
    @(negedge clk); start_drv = 1'b1;
    @(negedge clk); start_drv = 1'b0;
    begin
      int w = 0;
      while (!(valid0 && index0 == 5'd12) && w < 200) begin @(negedge clk); w++; end
      check("abort_reached_idx12", {valid0, index0}, {1'b1, 5'd12});
    end
    #2 reset = 1'b1;
    #1;
    check("abort_outputs", {valid0, busy0, hold0, done0}, '0);
    @(negedge clk);
    check("abort_no_done", done0, 1'b0);
    reset = 1'b0;
    run_dump(1'b0, -1, 0, -1, -1, 1'b0);
    check("post_reset_first_idx", (got_idx.size() > 0) ? got_idx[0] : 'x, 0);
    check("post_reset_beats", got_idx.size(), 32);
    check("post_reset_model", beat_mismatches(), 0);

    for (int r = 0; r < 4; r++) begin
      preload_random();
      run_dump(1'((r % 2)), -1, 0, -1, -1, 1'b1);
      check($sformatf("rand%0d_timeout", r), timed_out, 0);
      check($sformatf("rand%0d_model", r), beat_mismatches(), 0);
      check($sformatf("rand%0d_done", r), done_cnt, 1);
      check($sformatf("rand%0d_stable", r), stab_err, 0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
